// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, PC step and buffer entry type for the fetch front end
package fetch_pkg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;

    localparam logic [PC_W-1:0] PC_STEP = 32'd4;

    // One buffered instruction paired with the address it was fetched from.
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO of fetch entries with a single-cycle flush
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        empties the FIFO; push/pop in the same cycle are ignored
//   push         write push_data at the tail (caller guarantees not full)
//   push_data    entry to write
//   pop          drop the head entry (caller guarantees not empty)
//   head         head entry, all zeros while empty
//   empty        no entries held
//   count        number of entries held (0..DEPTH)
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    output fetch_entry_t  head,
    output logic          empty,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign empty = (cnt == '0);
    assign count = cnt;
    assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end: PC, request credits, redirect flush, decode buffer
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   redirect_valid, redirect_pc        load a new (word-aligned) PC, flush buffered/in-flight work
//   imem_req_valid/ready, imem_req_addr   fetch request to instruction memory
//   imem_rsp_valid, imem_rsp_data      in-order responses, never back-pressured
//   out_valid/ready, out_pc, out_instr    instruction stream toward decode
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [PC_W-1:0] pc;
    logic [CW-1:0]   credits;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   credits_next;
    logic [CW:0]     credits_avail;

    logic            rsp_drop;
    logic            rsp_accept;
    logic            pop_fire;
    logic            req_fire;

    fetch_entry_t    infl_push_data;
    fetch_entry_t    infl_head;
    logic            infl_empty;
    logic [CW-1:0]   infl_count;

    fetch_entry_t    buf_push_data;
    fetch_entry_t    buf_head;
    logic            buf_empty;
    logic [CW-1:0]   buf_count;

    always_comb begin
        // A response arriving with a redirect is stale by definition.
        rsp_drop   = imem_rsp_valid && ((drop_cnt != '0) || redirect_valid);
        rsp_accept = imem_rsp_valid && !rsp_drop;
        pop_fire   = !buf_empty && out_ready && !redirect_valid;

        // Credits freed this cycle are reusable immediately so a slot can be
        // refilled in the same cycle decode drains it (full rate at k <= DEPTH-1).
        credits_avail  = {1'b0, credits} + (CW+1)'(pop_fire) + (CW+1)'(rsp_drop);
        imem_req_valid = rst_n && !redirect_valid && (credits_avail != '0);
        req_fire       = imem_req_valid && imem_req_ready;

        credits_next = credits + CW'(pop_fire) + CW'(rsp_drop)
                     + (redirect_valid ? buf_count : '0) - CW'(req_fire);

        infl_push_data       = '0;
        infl_push_data.pc    = pc;
        buf_push_data        = infl_head;
        buf_push_data.instr  = imem_rsp_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC & 32'hFFFF_FFFC;
            credits  <= CW'(DEPTH);
            drop_cnt <= '0;
        end else begin
            credits <= credits_next;
            if (redirect_valid) begin
                pc <= redirect_pc & 32'hFFFF_FFFC;
                // Everything still in flight becomes stale; a response landing
                // this cycle is already consumed by rsp_drop.
                drop_cnt <= drop_cnt + infl_count - CW'(imem_rsp_valid);
            end else begin
                if (req_fire) begin
                    pc <= pc + PC_STEP;
                end
                if (rsp_drop) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
            end
        end
    end

    // In-flight queue: PC of each live request, head matches the next live response.
    fetch_fifo #(.DEPTH(DEPTH)) u_inflight (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (req_fire),
        .push_data (infl_push_data),
        .pop       (rsp_accept),
        .head      (infl_head),
        .empty     (infl_empty),
        .count     (infl_count)
    );

    // Instruction buffer toward decode.
    fetch_fifo #(.DEPTH(DEPTH)) u_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (rsp_accept),
        .push_data (buf_push_data),
        .pop       (pop_fire),
        .head      (buf_head),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    assign imem_req_addr = pc;
    assign out_valid     = !buf_empty;
    assign out_pc        = buf_head.pc;
    assign out_instr     = buf_head.instr;

    // A live response always has a matching in-flight entry.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(rsp_accept && infl_empty));
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic        ordy;
        logic        rv;
        logic [31:0] addr;
        logic        ov;
        logic [31:0] opc;
    } vec_t;

    mreq_t       mq[$];
    int          cyc = 0;
    int          last_due = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          nreq = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_req = RESET_PC;
    logic [31:0] exp_out = RESET_PC;
    logic [31:0] prev_pc = '0;
    logic [31:0] prev_instr = '0;
    logic        prev_hold = 1'b0;
    logic        after_redir = 1'b0;
    logic        s_rv;
    logic [31:0] s_ra;
    logic        s_ov;
    logic [31:0] s_opc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_instr", out_instr, 0);
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        out_ready      = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_hold_req_valid", imem_req_valid, 0);
        mq.delete();
        last_due    = cyc;
        exp_req     = RESET_PC;
        exp_out     = RESET_PC;
        prev_hold   = 1'b0;
        after_redir = 1'b0;
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive inputs and the memory response, then check
    // against the reference stream model.
    task automatic step(input logic redir, input logic [31:0] rpc,
                        input logic ordy, input logic rrdy);
        int due;
        @(negedge clk);
        redirect_valid = redir;
        redirect_pc    = rpc;
        out_ready      = ordy;
        imem_req_ready = rrdy;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mq[0].addr ^ 32'hFFFF_FFFF;
            void'(mq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        s_rv  = imem_req_valid;
        s_ra  = imem_req_addr;
        s_ov  = out_valid;
        s_opc = out_pc;
        if (prev_hold) begin
            chk("hold_valid", s_ov, 1);
            chk("hold_pc", s_opc, prev_pc);
            chk("hold_instr", out_instr, prev_instr);
        end
        if (after_redir) chk("flushed_out_valid", s_ov, 0);
        if (redir) chk("redirect_no_req", s_rv, 0);
        if (s_rv && rrdy) begin
            chk("req_addr", s_ra, exp_req);
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{addr: s_ra, due: due});
            exp_req += 32'd4;
            nreq++;
        end
        if (s_ov && ordy && !redir) begin
            chk("out_pc", s_opc, exp_out);
            chk("out_instr", out_instr, exp_out ^ 32'hFFFF_FFFF);
            exp_out += 32'd4;
        end
        if (redir) begin
            exp_req = rpc & 32'hFFFF_FFFC;
            exp_out = rpc & 32'hFFFF_FFFC;
        end
        chk("outstanding_bound", 32'(mq.size() <= DEPTH), 1);
        prev_hold   = s_ov && !ordy && !redir;
        prev_pc     = s_opc;
        prev_instr  = out_instr;
        after_redir = redir;
        cyc++;
    endtask

    // Drain everything, then stall decode: exactly DEPTH requests must issue.
    task automatic credit_restore(input string name);
        int n0;
        repeat (8) step(1'b0, '0, 1'b1, 1'b0);
        n0 = nreq;
        repeat (8) step(1'b0, '0, 1'b0, 1'b1);
        chk(name, nreq - n0, DEPTH);
    endtask

    vec_t tbl[11];

    initial begin
        int   n0;
        logic found;

        // cycle-by-cycle stream after reset, 1-cycle memory latency
        tbl[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        tbl[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        tbl[2]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
        tbl[3]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
        tbl[4]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
        tbl[5]  = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
        tbl[6]  = '{1'b0, 1'b0, 32'h18, 1'b1, 32'h10};
        tbl[7]  = '{1'b0, 1'b0, 32'h18, 1'b1, 32'h10};
        tbl[8]  = '{1'b0, 1'b0, 32'h18, 1'b1, 32'h10};
        tbl[9]  = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h10};
        tbl[10] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h14};

        #2;
        do_reset();
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 11; i++) begin
            step(1'b0, '0, tbl[i].ordy, 1'b1);
            chk($sformatf("tbl%0d_req_valid", i), s_rv, tbl[i].rv);
            chk($sformatf("tbl%0d_req_addr", i), s_ra, tbl[i].addr);
            chk($sformatf("tbl%0d_out_valid", i), s_ov, tbl[i].ov);
            chk($sformatf("tbl%0d_out_pc", i), s_opc, tbl[i].opc);
        end

        // backpressure from reset
        do_reset();
        n0 = nreq;
        repeat (10) step(1'b0, '0, 1'b0, 1'b1);
        chk("bp_req_count", nreq - n0, 2);
        chk("bp_req_valid_low", s_rv, 0);
        chk("bp_out_valid", s_ov, 1);
        chk("bp_out_pc", s_opc, 32'h0);
        step(1'b0, '0, 1'b1, 1'b1);
        chk("bp_resume_valid", s_rv, 1);
        chk("bp_resume_addr", s_ra, 32'h8);

        // redirect with two requests in flight, 3-cycle latency
        do_reset();
        lat_min = 3; lat_max = 3;
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        chk("rd_outstanding", mq.size(), 2);
        step(1'b1, 32'h0000_0103, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        chk("rd_next_req_valid", s_rv, 1);
        chk("rd_next_req_addr", s_ra, 32'h0000_0100);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, '0, 1'b1, 1'b1);
            if (s_ov) begin
                found = 1'b1;
                chk("rd_first_out_pc", s_opc, 32'h0000_0100);
            end
        end
        if (!found) chk("rd_out_timeout", 0, 1);

        // redirect together with a response and a decode pop
        do_reset();
        lat_min = 1; lat_max = 1;
        repeat (6) step(1'b0, '0, 1'b1, 1'b1);
        step(1'b1, 32'h0000_0200, 1'b1, 1'b1);
        chk("sim_rsp_present", imem_rsp_valid, 1);
        chk("sim_out_present", s_ov, 1);
        repeat (6) step(1'b0, '0, 1'b1, 1'b1);
        credit_restore("sim_credits_full");

        // randomized traffic against the stream model
        do_reset();
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 15) == 0, $urandom,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end
        credit_restore("rand_credits_full");

        // address wrap
        lat_min = 1; lat_max = 1;
        step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        chk("wrap_req_addr0", s_ra, 32'hFFFF_FFFC);
        step(1'b0, '0, 1'b1, 1'b1);
        chk("wrap_req_valid1", s_rv, 1);
        chk("wrap_req_addr1", s_ra, 32'h0000_0000);
        repeat (4) step(1'b0, '0, 1'b1, 1'b1);
        chk("wrap_stream_valid", s_ov, 1);

        // asynchronous reset mid-stream
        @(posedge clk);
        #3;
        do_reset();
        step(1'b0, '0, 1'b1, 1'b1);
        chk("restart_req_valid", s_rv, 1);
        chk("restart_req_addr", s_ra, RESET_PC);
        repeat (6) step(1'b0, '0, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
